gear_hydraulic_sequencer: RTL

Sits between the landing-gear controller and the physical hydraulics. It turns the controller's Pump and Valve requests into safely ordered solenoid and pump-motor drive: the valve is set before the pump starts, and pressure bleeds off before the valve can move. It also supervises gear transit with a watchdog and generates the TimeUp signal from the controller's Timer restart request.

---
 rtl/gear_hydraulic_sequencer_if.sv | 24 ++
 rtl/gear_hydraulic_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gear_hydraulic_sequencer_if.sv
// Signal bundle between the landing-gear controller (master) and the
// hydraulic sequencer (slave): requests and sensors in, drives and status out.
interface gear_hydraulic_sequencer_if;
   logic Pump;
   logic Valve;
   logic GearIsDown;
   logic GearIsUp;
   logic Timer;
   logic PumpMotor;
   logic ValveSolenoid;
   logic TimeUp;
   logic Busy;
   logic Fault;

   modport master (
      output Pump, Valve, GearIsDown, GearIsUp, Timer,
      input  PumpMotor, ValveSolenoid, TimeUp, Busy, Fault
   );

   modport slave (
      input  Pump, Valve, GearIsDown, GearIsUp, Timer,
      output PumpMotor, ValveSolenoid, TimeUp, Busy, Fault
   );
endinterface

// File: rtl/gear_hydraulic_sequencer.sv
// Orders valve/pump drive for the landing gear (valve first, bleed after),
// supervises transit with a watchdog and derives TimeUp from Timer restarts.
module gear_hydraulic_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned BLEED_CYCLES  = 4,
   parameter int unsigned TRANSIT_LIMIT = 16,
   parameter int unsigned TIMEUP_CYCLES = 8,
   parameter int unsigned CW            = 8
) (
   input logic                       Clock,
   input logic                       Clear,
   gear_hydraulic_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RUN,
      ST_BLEED,
      ST_FAULT
   } state_t;

   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] BLEED_LAST   = CW'(BLEED_CYCLES - 1);
   localparam logic [CW-1:0] TRANSIT_LAST = CW'(TRANSIT_LIMIT - 1);
   localparam logic [CW-1:0] TIMEUP_MAX   = CW'(TIMEUP_CYCLES);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CNT_ONE;
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] tcnt_q, tcnt_d;
   logic          pump_motor_q, pump_motor_d;
   logic          valve_sol_q, valve_sol_d;
   logic          time_up_q, time_up_d;
   logic          busy_q, busy_d;
   logic          fault_q, fault_d;

   logic conflict;
   logic tgt_run;
   logic tgt_req;
   logic reversal;

   // tgt_run follows the latched direction; tgt_req judges a new request.
   assign conflict = bus.GearIsDown & bus.GearIsUp;
   assign tgt_run  = valve_sol_q ? bus.GearIsDown : bus.GearIsUp;
   assign tgt_req  = bus.Valve   ? bus.GearIsDown : bus.GearIsUp;
   assign reversal = bus.Pump & (bus.Valve != valve_sol_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valve_sol_d = valve_sol_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.Pump && !tgt_req) begin
               valve_sol_d = bus.Valve;
               cnt_d       = '0;
               state_d     = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (conflict) begin
               cnt_d   = '0;
               state_d = ST_FAULT;
            end else if (!bus.Pump) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_RUN: begin
            // Reaching the target wins over the watchdog on the limit cycle.
            if (conflict) begin
               cnt_d   = '0;
               state_d = ST_FAULT;
            end else if (!bus.Pump || tgt_run || reversal) begin
               cnt_d   = '0;
               state_d = ST_BLEED;
            end else if (cnt_q == TRANSIT_LAST) begin
               cnt_d   = '0;
               state_d = ST_FAULT;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_BLEED: begin
            if (conflict) begin
               cnt_d   = '0;
               state_d = ST_FAULT;
            end else if (cnt_q == BLEED_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_FAULT;
         end
      endcase

      pump_motor_d = (state_d == ST_RUN);
      busy_d       = (state_d != ST_IDLE);
      fault_d      = (state_d == ST_FAULT);
   end

   // Timer path runs regardless of the sequencer state, including FAULT.
   always_comb begin
      tcnt_d = tcnt_q;
      if (bus.Timer) begin
         tcnt_d = '0;
      end else if (tcnt_q != TIMEUP_MAX) begin
         tcnt_d = tcnt_q + CNT_ONE;
      end
      time_up_d = (tcnt_d == TIMEUP_MAX);
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pump_motor_q <= 1'b0;
         valve_sol_q  <= 1'b0;
         busy_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pump_motor_q <= pump_motor_d;
         valve_sol_q  <= valve_sol_d;
         busy_q       <= busy_d;
         fault_q      <= fault_d;
      end
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         tcnt_q    <= '0;
         time_up_q <= 1'b0;
      end else begin
         tcnt_q    <= tcnt_d;
         time_up_q <= time_up_d;
      end
   end

   assign bus.PumpMotor     = pump_motor_q;
   assign bus.ValveSolenoid = valve_sol_q;
   assign bus.TimeUp        = time_up_q;
   assign bus.Busy          = busy_q;
   assign bus.Fault         = fault_q;

endmodule
